// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the stage sequencer (master) and the host/stage side (slave).
// Carries the launch/done/abort signals and the shared-memory mux selects.
interface stage_sequencer_if #(
    parameter int NUM_STAGES = 8,
    parameter int SEL_WIDTH  = 3
);
    // Strict level/pulse semantics: start is sampled only while the sequencer is idle;
    // stage_start is a one-cycle launch pulse; stage_done is a level whose rising edge
    // completes the current stage, and abort_req is read together with that rise.
    logic                  start;
    logic [NUM_STAGES-1:0] stage_enable;
    logic [NUM_STAGES-1:0] stage_done;
    logic [NUM_STAGES-1:0] abort_req;
    logic [NUM_STAGES-1:0] stage_start;
    logic [SEL_WIDTH-1:0]  addr_select;
    logic [SEL_WIDTH-1:0]  wr_select;
    logic                  wr_gate;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic [SEL_WIDTH-1:0]  abort_stage;
    logic                  timeout;

    modport master (
        input  start, stage_enable, stage_done, abort_req,
        output stage_start, addr_select, wr_select, wr_gate,
               busy, done, aborted, abort_stage, timeout
    );

    modport slave (
        output start, stage_enable, stage_done, abort_req,
        input  stage_start, addr_select, wr_select, wr_gate,
               busy, done, aborted, abort_stage, timeout
    );
endinterface

// File: rtl/stage_sequencer.sv
// Runs the per-packet processing stages one at a time and steers the shared memory port muxes.
// Optional per-stage watchdog: define STAGE_TIMEOUT_EN to enable it.
module stage_sequencer #(
    parameter int                    NUM_STAGES     = 8,
    parameter int                    SEL_WIDTH      = 3,
    parameter logic [NUM_STAGES-1:0] WR_MASK        = NUM_STAGES'('hAF),
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                    clock,
    input  logic                    nrst,
    stage_sequencer_if.master       bus,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_STAGES - 1);

    if ((2 ** SEL_WIDTH) < NUM_STAGES || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("stage_sequencer: SEL_WIDTH too narrow or TIMEOUT_CYCLES < 1");
    end

    state_e                state_q, state_d;
    logic [SEL_WIDTH-1:0]  idx_q, idx_d;
    logic [NUM_STAGES-1:0] en_q, en_d;
    logic [NUM_STAGES-1:0] done_q;
    logic                  aborted_q, aborted_d;
    logic [SEL_WIDTH-1:0]  abort_stage_q, abort_stage_d;
    logic                  timeout_q, timeout_d;

    logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  wr_gate_q, wr_gate_d;
    logic                  busy_q, busy_d;
    logic                  done_pulse_q, done_pulse_d;

    logic [NUM_STAGES-1:0] cur_oh, nxt_oh;
    logic                  cur_en, cur_rise, cur_abort, cur_last;

`ifdef STAGE_TIMEOUT_EN
    localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]             cnt_q, cnt_d;
`endif

    // Only the current stage is looked at; other stages' done/abort levels are ignored.
    always_comb begin
        cur_oh = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            cur_oh[i] = (idx_q == SEL_WIDTH'(i));
        end
    end

    assign cur_en    = |(en_q & cur_oh);
    assign cur_rise  = |(bus.stage_done & ~done_q & cur_oh);
    assign cur_abort = |(bus.abort_req & cur_oh);
    assign cur_last  = (idx_q == LAST_IDX);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        en_d          = en_q;
        aborted_d     = aborted_q;
        abort_stage_d = abort_stage_q;
        timeout_d     = timeout_q;
`ifdef STAGE_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    idx_d         = '0;
                    en_d          = bus.stage_enable;
                    aborted_d     = 1'b0;
                    abort_stage_d = '0;
                    timeout_d     = 1'b0;
                    state_d       = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (cur_en) begin
                    state_d = S_WAIT;
`ifdef STAGE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (cur_last) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d = idx_q + SEL_WIDTH'(1);
                end
            end
            S_WAIT: begin
`ifdef STAGE_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                // A completion seen on the watchdog's last cycle still advances normally.
                if (cur_rise) begin
                    if (cur_abort) begin
                        aborted_d     = 1'b1;
                        abort_stage_d = idx_q;
                        state_d       = S_FINISH;
                    end else if (cur_last) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + SEL_WIDTH'(1);
                        state_d = S_LAUNCH;
                    end
                end
`ifdef STAGE_TIMEOUT_EN
                else if (cnt_q == CNT_LIMIT) begin
                    timeout_d     = 1'b1;
                    aborted_d     = 1'b1;
                    abort_stage_d = idx_q;
                    state_d       = S_FINISH;
                end
`endif
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registered copies line up with the FSM.
    always_comb begin
        nxt_oh = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            nxt_oh[i] = (idx_d == SEL_WIDTH'(i));
        end
        stage_start_d = (state_d == S_LAUNCH) ? (en_d & nxt_oh) : '0;
        sel_d         = (state_d == S_IDLE) ? '0 : idx_d;
        wr_gate_d     = ((state_d == S_LAUNCH) || (state_d == S_WAIT)) && |(WR_MASK & nxt_oh);
        busy_d        = (state_d != S_IDLE);
        done_pulse_d  = (state_d == S_FINISH);
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            en_q          <= '0;
            done_q        <= '0;
            aborted_q     <= 1'b0;
            abort_stage_q <= '0;
            timeout_q     <= 1'b0;
            stage_start_q <= '0;
            sel_q         <= '0;
            wr_gate_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            en_q          <= en_d;
            done_q        <= bus.stage_done;
            aborted_q     <= aborted_d;
            abort_stage_q <= abort_stage_d;
            timeout_q     <= timeout_d;
            stage_start_q <= stage_start_d;
            sel_q         <= sel_d;
            wr_gate_q     <= wr_gate_d;
            busy_q        <= busy_d;
            done_pulse_q  <= done_pulse_d;
        end
    end

`ifdef STAGE_TIMEOUT_EN
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.stage_start = stage_start_q;
    assign bus.addr_select = sel_q;
    assign bus.wr_select   = sel_q;
    assign bus.wr_gate     = wr_gate_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_pulse_q;
    assign bus.aborted     = aborted_q;
    assign bus.abort_stage = abort_stage_q;
    assign bus.timeout     = timeout_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a behavioural stage model answers launches, a scoreboard
// queue holds the expected launch order, and each run is checked for length and exit status.
module tb_stage_sequencer;

    localparam int NS = 8;
    localparam int SW = 3;
`ifdef STAGE_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif
    localparam logic [NS-1:0] MASK = 8'hAF;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_WAIT = 2'd2, ST_FINISH = 2'd3;

    logic       clock = 1'b0;
    logic       nrst  = 1'b0;
    logic [1:0] dbg_state;

    stage_sequencer_if #(.NUM_STAGES(NS), .SEL_WIDTH(SW)) bus ();

    stage_sequencer #(
        .NUM_STAGES(NS), .SEL_WIDTH(SW), .WR_MASK(MASK), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .nrst(nrst), .bus(bus), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    int              total = 0;
    int              bad = 0;
    int              done_seen = 0;
    logic [SW-1:0]   exp_q[$];
    int              delay[NS];
    int              cnt[NS];
    logic [NS-1:0]   abort_plan = '0;
    logic [NS-1:0]   freeze = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stage model: a launch clears the stage's done/abort, done rises delay[i] cycles later.
    // A frozen stage ignores launches and keeps its done level as it is.
    always @(negedge clock) begin
        if (!nrst) begin
            bus.stage_done = '0;
            bus.abort_req  = '0;
            for (int i = 0; i < NS; i++) cnt[i] = 0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (!freeze[i]) begin
                    if (bus.stage_start[i]) begin
                        bus.stage_done[i] = 1'b0;
                        bus.abort_req[i]  = 1'b0;
                        cnt[i] = delay[i];
                    end else if (cnt[i] != 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            bus.stage_done[i] = 1'b1;
                            bus.abort_req[i]  = abort_plan[i];
                        end
                    end
                end
            end
        end
    end

    // Scoreboard side: every launch pulse is popped against the expected order.
    always @(negedge clock) begin
        logic [SW-1:0] exp_id;
        if (nrst) begin
            if (bus.done === 1'b1) done_seen++;
            check("sel_match", bus.wr_select, bus.addr_select);
            if (dbg_state == 2'd1 || dbg_state == ST_WAIT)
                check("wr_gate_run", bus.wr_gate, MASK[bus.addr_select]);
            else
                check("wr_gate_off", bus.wr_gate, 0);
            if (bus.stage_start !== '0) begin
                check("start_onehot", $onehot(bus.stage_start), 1);
                for (int i = 0; i < NS; i++) begin
                    if (bus.stage_start[i]) begin
                        check("start_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            exp_id = exp_q.pop_front();
                            check("start_order", i, exp_id);
                        end
                        check("start_addr", bus.addr_select, i);
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic [NS-1:0] en);
        @(negedge clock);
        bus.stage_enable = en;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_for(input logic [SW-1:0] idx, input logic [1:0] st, input string tag);
        int n = 0;
        while (!(bus.addr_select == idx && dbg_state == st) && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(tag, (bus.addr_select == idx && dbg_state == st), 1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        nrst = 1'b0;
        #1;
        check("rst_start", bus.stage_start, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_addr", bus.addr_select, 0);
        check("rst_aborted", bus.aborted, 0);
        check("rst_abort_stage", bus.abort_stage, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_state", dbg_state, ST_IDLE);
        exp_q.delete();
        freeze = '0;
        abort_plan = '0;
        @(negedge clock);
        nrst = 1'b1;
    endtask

    // One full packet: bench-side prediction of launch order, run length and exit status.
    task automatic run_packet(input logic [NS-1:0] en, input logic [NS-1:0] ab,
                              input logic [NS-1:0] fz, input string tag);
        int n, exp_n, d0;
        bit stop;
        logic exp_aborted, exp_timeout;
        logic [SW-1:0] exp_stage;
        for (int i = 0; i < NS; i++) delay[i] = $urandom_range(1, 4);
        abort_plan = ab;
        freeze = fz;
        exp_n = 0; stop = 0;
        exp_aborted = 0; exp_timeout = 0; exp_stage = '0;
        for (int i = 0; i < NS; i++) begin
            if (!stop) begin
                if (!en[i]) begin
                    exp_n += 1;
                end else begin
                    exp_q.push_back(SW'(i));
                    if (fz[i]) begin
                        exp_n += 1 + TO;
                        exp_aborted = 1; exp_timeout = 1; exp_stage = SW'(i); stop = 1;
                    end else begin
                        exp_n += 1 + delay[i];
                        if (ab[i]) begin
                            exp_aborted = 1; exp_stage = SW'(i); stop = 1;
                        end
                    end
                end
            end
        end
        exp_n += 1;
        d0 = done_seen;
        pulse_start(en);
        n = 1;
        check({tag, "_accept_busy"}, bus.busy, 1);
        check({tag, "_accept_aborted_clr"}, bus.aborted, 0);
        check({tag, "_accept_timeout_clr"}, bus.timeout, 0);
        while (bus.done !== 1'b1 && n < exp_n + 50) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_cycles"}, n, exp_n);
        check({tag, "_busy_in_finish"}, bus.busy, 1);
        check({tag, "_aborted"}, bus.aborted, exp_aborted);
        check({tag, "_abort_stage"}, bus.abort_stage, exp_stage);
        check({tag, "_timeout"}, bus.timeout, exp_timeout);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        @(negedge clock);
        check({tag, "_post_busy"}, bus.busy, 0);
        check({tag, "_post_done"}, bus.done, 0);
        check({tag, "_post_addr"}, bus.addr_select, 0);
        check({tag, "_post_aborted_held"}, bus.aborted, exp_aborted);
        check({tag, "_post_stage_held"}, bus.abort_stage, exp_stage);
        check({tag, "_done_pulses"}, done_seen - d0, 1);
        abort_plan = '0;
        freeze = '0;
    endtask

    initial begin
        int d0;
        bus.start = 1'b0;
        bus.stage_enable = '0;
        for (int i = 0; i < NS; i++) delay[i] = 1;
        repeat (3) @(negedge clock);
        do_reset();

        run_packet(8'hFF, 8'h00, 8'h00, "all_enabled");
        run_packet(8'hFF, 8'h02, 8'h00, "abort_stage1");
        run_packet(8'hEF, 8'h00, 8'h00, "skip_stage4");
        run_packet(8'hFF, 8'h80, 8'h00, "abort_last");
        run_packet(8'h5A, 8'h00, 8'h00, "sparse_enable");

        // Stage 3 done is still high from the previous full run and never re-rises.
        for (int i = 0; i < NS; i++) delay[i] = $urandom_range(1, 4);
        freeze = 8'h08;
        for (int i = 0; i < 4; i++) exp_q.push_back(SW'(i));
        d0 = done_seen;
        pulse_start(8'hFF);
        wait_for(SW'(3), ST_WAIT, "stale_reach_wait3");
        repeat (30) @(negedge clock);
        check("stale_state", dbg_state, ST_WAIT);
        check("stale_addr", bus.addr_select, 3);
        check("stale_busy", bus.busy, 1);
        check("stale_no_done", done_seen - d0, 0);
        check("stale_sb_empty", exp_q.size(), 0);
        do_reset();

        // Start while busy is ignored; reset in stage 5 WAIT aborts the run silently.
        for (int i = 0; i < NS; i++) delay[i] = $urandom_range(1, 4);
        for (int i = 0; i < NS; i++) exp_q.push_back(SW'(i));
        d0 = done_seen;
        pulse_start(8'hFF);
        repeat (6) @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        wait_for(SW'(5), ST_WAIT, "midrst_reach_wait5");
        do_reset();
        check("midrst_no_done", done_seen - d0, 0);
        run_packet(8'hFF, 8'h00, 8'h00, "after_reset");

`ifdef STAGE_TIMEOUT_EN
        do_reset();
        run_packet(8'hFF, 8'h00, 8'h04, "timeout_stage2");
`endif

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
